// File: rtl/antitheft_timer_if.sv
// ---------------------------------------------------------------------------
// | Module   : antitheft_timer_if                                           |
// | Desc     : Request/parameter bundle between the anti-theft controller   |
// |            FSM (master) and the programmable countdown timer (slave).   |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none

interface antitheft_timer_if #(
  parameter int W = 4
) ();

  logic         one_hz_enable;   // one-clock tick, once per second
  logic         start_timer;     // level: countdown wanted
  logic [1:0]   interval;        // parameter select for the countdown
  logic         reprogram;       // one-clock write strobe
  logic [1:0]   time_param_sel;  // parameter index to write
  logic [W-1:0] time_value;      // value to write
  logic         expired;         // one-clock pulse at end of countdown
  logic [W-1:0] seconds_left;    // remaining seconds, 0 when idle

  // Controller side: issues requests, observes completion.
  modport master (
    output one_hz_enable,
    output start_timer,
    output interval,
    output reprogram,
    output time_param_sel,
    output time_value,
    input  expired,
    input  seconds_left
  );

  // Timer side.
  modport slave (
    input  one_hz_enable,
    input  start_timer,
    input  interval,
    input  reprogram,
    input  time_param_sel,
    input  time_value,
    output expired,
    output seconds_left
  );

endinterface

`default_nettype wire

// File: rtl/antitheft_timer.sv
// ---------------------------------------------------------------------------
// | Module   : antitheft_timer                                              |
// | Desc     : Programmable seconds countdown for the anti-theft controller.|
// |            Holds four reprogrammable time parameters, counts the        |
// |            selected one down on the 1 Hz tick and pulses 'expired'.     |
// | Config   : ANTITHEFT_FAST_TICK_EN - every clock is a tick (debug).      |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none

module antitheft_timer #(
  parameter int W                 = 4,
  parameter int T_ARM_DELAY       = 6,
  parameter int T_DRIVER_DELAY    = 8,
  parameter int T_PASSENGER_DELAY = 15,
  parameter int T_ALARM_ON        = 10
) (
  input  wire logic         clock,
  input  wire logic         reset,   // asynchronous, active-low
  antitheft_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [W-1:0] c_one  = W'(1);
  localparam logic [W-1:0] c_zero = '0;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_count;
  logic [W-1:0] w_count_nxt;
  logic [1:0]   r_latched;
  logic [1:0]   w_latched_nxt;
  logic         r_expired;
  logic         w_expired_nxt;
  logic [W-1:0] r_table [4];
  logic [W-1:0] w_wr_val;
  logic [W-1:0] w_load_val;
  logic         w_tick;

`ifdef ANTITHEFT_FAST_TICK_EN
  // Debug build: the 1 Hz input is ignored, every cycle counts as a second.
  assign w_tick = 1'b1;
`else
  assign w_tick = bus.one_hz_enable;
`endif

  // A programmed time of zero would never expire cleanly; clamp to 1 s.
  assign w_wr_val   = (bus.time_value == c_zero) ? c_one : bus.time_value;
  assign w_load_val = r_table[bus.interval];

  // Parameter table: restored to build-time defaults on reset, written on reprogram.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_table[0] <= W'(T_ARM_DELAY);
      r_table[1] <= W'(T_DRIVER_DELAY);
      r_table[2] <= W'(T_PASSENGER_DELAY);
      r_table[3] <= W'(T_ALARM_ON);
    end else if (bus.reprogram) begin
      r_table[bus.time_param_sel] <= w_wr_val;
    end
  end

  // State, counter, latched interval and registered expiry pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_count   <= c_zero;
      r_latched <= 2'd0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_latched <= w_latched_nxt;
      r_expired <= w_expired_nxt;
    end
  end

  // Next-state logic. Priority in COUNT/DONE: reprogram abort, start drop,
  // interval reload, then the tick. A load therefore swallows a same-cycle
  // tick, and a reload on the final tick suppresses the expiry pulse.
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_latched_nxt = r_latched;
    w_expired_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_count_nxt = c_zero;
        if (bus.start_timer && !bus.reprogram) begin
          w_count_nxt   = w_load_val;
          w_latched_nxt = bus.interval;
          w_state_nxt   = ST_COUNT;
        end
      end
      ST_COUNT, ST_DONE: begin
        if (bus.reprogram || !bus.start_timer) begin
          w_count_nxt = c_zero;
          w_state_nxt = ST_IDLE;
        end else if (bus.interval != r_latched) begin
          w_count_nxt   = w_load_val;
          w_latched_nxt = bus.interval;
          w_state_nxt   = ST_COUNT;
        end else if ((r_state == ST_COUNT) && w_tick) begin
          if (r_count <= c_one) begin
            // Final second: DONE has no path back to here without a load,
            // so the pulse can never repeat on the next cycle.
            w_count_nxt   = c_zero;
            w_expired_nxt = 1'b1;
            w_state_nxt   = ST_DONE;
          end else begin
            w_count_nxt = r_count - c_one;
          end
        end
      end
      default: begin
        w_count_nxt = c_zero;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.expired      = r_expired;
  assign bus.seconds_left = r_count;

endmodule

`default_nettype wire

// File: tb/tb_antitheft_timer.sv
// ---------------------------------------------------------------------------
// | Module   : tb_antitheft_timer                                           |
// | Desc     : Directed self-checking bench for antitheft_timer.            |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_antitheft_timer;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;
  int   pulse_cnt;
  int   p0;

  antitheft_timer_if #(.W(4)) bus ();

  antitheft_timer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Counts every cycle in which expired is high.
  always @(posedge clock) if (bus.expired === 1'b1) pulse_cnt++;

  // Safety net: never hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One-cycle 1 Hz tick sampled by the next rising edge; returns at the negedge after it.
  task automatic do_tick();
    bus.one_hz_enable = 1'b1;
    @(negedge clock);
    bus.one_hz_enable = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0; pulse_cnt = 0; p0 = 0;
    reset = 1'b0;
    bus.one_hz_enable = 1'b0;
    bus.start_timer = 1'b0;
    bus.interval = 2'd0;
    bus.reprogram = 1'b0;
    bus.time_param_sel = 2'd0;
    bus.time_value = 4'd0;
    repeat (3) @(negedge clock);
    chk("rst_expired", 32'(bus.expired), 0);
    chk("rst_seconds", 32'(bus.seconds_left), 0);
    reset = 1'b1;
    @(negedge clock);

`ifdef ANTITHEFT_FAST_TICK_EN
    // Fast ticks: default arm delay 6 expires on the 6th cycle after load.
    bus.start_timer = 1'b1; bus.interval = 2'd0;
    @(negedge clock);
    chk("fast_load", 32'(bus.seconds_left), 6);
    repeat (5) @(negedge clock);
    chk("fast_sl1", 32'(bus.seconds_left), 1);
    chk("fast_noexp", 32'(bus.expired), 0);
    @(negedge clock);
    chk("fast_exp", 32'(bus.expired), 1);
    chk("fast_sl0", 32'(bus.seconds_left), 0);
    @(negedge clock);
    chk("fast_exp_once", 32'(bus.expired), 0);
`else
    // Driver delay 8 s, ticks spaced apart.
    p0 = pulse_cnt;
    bus.start_timer = 1'b1; bus.interval = 2'd1;
    @(negedge clock);
    chk("drv_load", 32'(bus.seconds_left), 8);
    for (int i = 1; i <= 8; i++) begin
      do_tick();
      chk("drv_count", 32'(bus.seconds_left), 32'(8 - i));
      chk("drv_expired", 32'(bus.expired), (i == 8) ? 32'd1 : 32'd0);
      repeat (3) @(negedge clock);
    end
    chk("drv_done_hold", 32'(bus.seconds_left), 0);
    chk("drv_pulses", 32'(pulse_cnt - p0), 1);

    // Passenger 15 s, then hand-off to alarm-on 10 s with start held.
    p0 = pulse_cnt;
    bus.interval = 2'd2;
    @(negedge clock);
    chk("pass_load", 32'(bus.seconds_left), 15);
    repeat (15) do_tick();
    chk("pass_expired", 32'(bus.expired), 1);
    repeat (3) @(negedge clock);
    chk("pass_one_cycle", 32'(bus.expired), 0);
    bus.interval = 2'd3;
    @(negedge clock);
    chk("alarm_reload", 32'(bus.seconds_left), 10);
    chk("alarm_no_extra", 32'(pulse_cnt - p0), 1);
    repeat (9) do_tick();
    chk("alarm_sl1", 32'(bus.seconds_left), 1);
    chk("alarm_noexp", 32'(bus.expired), 0);
    do_tick();
    chk("alarm_expired", 32'(bus.expired), 1);
    repeat (2) @(negedge clock);
    chk("alarm_pulses", 32'(pulse_cnt - p0), 2);

    // Reprogram arm delay to 3.
    bus.start_timer = 1'b0;
    @(negedge clock);
    bus.reprogram = 1'b1; bus.time_param_sel = 2'd0; bus.time_value = 4'd3;
    @(negedge clock);
    bus.reprogram = 1'b0;
    bus.start_timer = 1'b1; bus.interval = 2'd0;
    @(negedge clock);
    chk("arm3_load", 32'(bus.seconds_left), 3);
    repeat (2) do_tick();
    chk("arm3_noexp", 32'(bus.expired), 0);
    do_tick();
    chk("arm3_expired", 32'(bus.expired), 1);

    // A written zero is stored as 1.
    bus.start_timer = 1'b0;
    @(negedge clock);
    bus.reprogram = 1'b1; bus.time_param_sel = 2'd0; bus.time_value = 4'd0;
    @(negedge clock);
    bus.reprogram = 1'b0;
    bus.start_timer = 1'b1;
    @(negedge clock);
    chk("arm0_load", 32'(bus.seconds_left), 1);
    do_tick();
    chk("arm0_expired", 32'(bus.expired), 1);

    // Reprogram beats a load; then a load beats a same-cycle tick.
    bus.start_timer = 1'b0;
    @(negedge clock);
    bus.start_timer = 1'b1; bus.interval = 2'd0; bus.one_hz_enable = 1'b1;
    bus.reprogram = 1'b1; bus.time_param_sel = 2'd0; bus.time_value = 4'd5;
    @(negedge clock);
    chk("reprog_wins", 32'(bus.seconds_left), 0);
    bus.reprogram = 1'b0;
    @(negedge clock);
    bus.one_hz_enable = 1'b0;
    chk("load_beats_tick", 32'(bus.seconds_left), 5);
    repeat (4) do_tick();
    chk("arm5_sl1", 32'(bus.seconds_left), 1);
    // Interval change on the final tick: reload, no pulse.
    bus.interval = 2'd1; bus.one_hz_enable = 1'b1;
    @(negedge clock);
    bus.one_hz_enable = 1'b0;
    chk("reload_final_sl", 32'(bus.seconds_left), 8);
    chk("reload_final_noexp", 32'(bus.expired), 0);

    // Drop start at 4 s, then raise again.
    repeat (4) do_tick();
    chk("drop_sl4", 32'(bus.seconds_left), 4);
    p0 = pulse_cnt;
    bus.start_timer = 1'b0;
    @(negedge clock);
    chk("drop_sl0", 32'(bus.seconds_left), 0);
    chk("drop_noexp", 32'(bus.expired), 0);
    repeat (3) @(negedge clock);
    bus.start_timer = 1'b1;
    @(negedge clock);
    chk("raise_reload", 32'(bus.seconds_left), 8);
    chk("drop_pulses", 32'(pulse_cnt - p0), 0);

    // Reprogram mid-count aborts; entry 3 := 2; async reset restores 10.
    bus.reprogram = 1'b1; bus.time_param_sel = 2'd3; bus.time_value = 4'd2;
    @(negedge clock);
    bus.reprogram = 1'b0;
    chk("reprog_abort", 32'(bus.seconds_left), 0);
    @(negedge clock);
    chk("reprog_restart", 32'(bus.seconds_left), 8);
    bus.interval = 2'd3;
    @(negedge clock);
    chk("alarm2_load", 32'(bus.seconds_left), 2);
    do_tick();
    chk("alarm2_sl1", 32'(bus.seconds_left), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_sl", 32'(bus.seconds_left), 0);
    chk("async_rst_exp", 32'(bus.expired), 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("restored_load", 32'(bus.seconds_left), 10);
    repeat (9) do_tick();
    chk("restored_noexp", 32'(bus.expired), 0);
    do_tick();
    chk("restored_expired", 32'(bus.expired), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
